dmem_resp: RTL and testbench
============================

# dmem_resp

Data-memory responder for the pipelined MIPS core: the slave end of the core's load/store port. It accepts one request at a time, holds the pipeline with `oStall` for a programmable number of wait states, then completes the access. Completion is marked by a one-cycle `oValid` pulse, with read data and an error flag. It replaces the zero-latency data-memory model so the core's stall path can be exercised against realistic memory timing.

## Interface
- `DEPTH_LOG2`, 10: log2 of word count; storage is 2^DEPTH_LOG2 x 32 bits.
- `WAIT_CYCLES`, 2: wait states between acceptance and response; range 0..15.
- `clk`  in  1  clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `iReq`  in  1  request valid; held by the core until the `oValid` cycle.
- `iWr`  in  1  1 = store, 0 = load.
- `iAddr`  in  32  byte address.
- `iWrData`  in  32  store data.
- `iByteEn`  in  4  store byte lanes; bit n covers bits [8n+7:8n]; ignored on loads.
- `oStall`  out  1  freeze the core pipeline this cycle.
- `oValid`  out  1  one-cycle completion pulse.
- `oRdData`  out  32  load data, registered.
- `oErr`  out  1  access faulted; valid only while `oValid` = 1.

## Operation
- The FSM has three states: IDLE, WAIT and RESP. A 4-bit wait counter `cnt` runs alongside it.
- **IDLE with `iReq` = 1:** accept the request.
  - Latch `iWr`, `iAddr`, `iWrData` and `iByteEn`.
  - If `WAIT_CYCLES` = 0, go to RESP. Otherwise load `cnt` = `WAIT_CYCLES` - 1 and go to WAIT.
- **WAIT:** if `cnt` = 0, go to RESP; otherwise decrement `cnt`.
- **RESP:** always returns to IDLE.
  - The request still held on `iReq` in this cycle is the one being answered. It is never re-accepted.
- **Word index:** latched `iAddr[DEPTH_LOG2+1:2]`.
- **Out-of-range address:** if any of `iAddr[31:DEPTH_LOG2+2]` is nonzero, the access faults.
  - Loads and stores both fault; no store occurs.
  - `oRdData` is forced to 0 and `oErr` = 1 in RESP.
- **Store, no fault:** commits at the RESP clock edge.
  - Only lanes with `iByteEn` bit = 1 are written; other lanes keep their old value.
  - `iByteEn` = 0000 is legal: the word is unchanged and `oValid` still pulses.
  - `oRdData` is unchanged by a store.
- **Load, no fault:** `oRdData` takes the full 32-bit word, registered on the edge entering RESP. It holds that value until the next load response or reset.
- **Memory array:** not reset. Its contents are undefined until written.

## Timing
- `oStall` = (IDLE & `iReq`) | WAIT. It is combinational from state and `iReq`.
- `oValid` = 1 exactly in RESP; `oStall` = 0 in RESP, so the core advances on that edge.
- **Latency:** `oValid` is asserted `WAIT_CYCLES` + 1 cycles after the acceptance cycle.
  - `oStall` is high for `WAIT_CYCLES` + 1 cycles per access.
- **Throughput:** one access per `WAIT_CYCLES` + 2 cycles, because of the mandatory IDLE cycle after RESP.
- Changes to `iReq`, `iAddr` or other request inputs after acceptance are ignored; they are latched.
- **Reset values** (immediate on `resetn` low): state IDLE, `cnt` = 0, `oValid` = 0, `oErr` = 0, `oRdData` = 0.
  - `oStall` then follows `iReq`.
- **Reset mid-access:** the access is abandoned.
  - A store not yet at RESP is not committed.
  - No `oValid` is produced for the abandoned access.

## Configuration
- **`DMEM_ALIGN_CHECK_EN` defined:** any access with `iAddr[1:0]` != 00 faults.
  - No store occurs, `oRdData` = 0 and `oErr` = 1 in RESP.
  - The fault applies to loads and stores.
- **Undefined:** `iAddr[1:0]` is ignored, so the access hits the containing word; only range faults set `oErr`.
- Cycle timing is identical in both builds.

## Test plan
- `WAIT_CYCLES` = 2, store `iAddr` = 0x10, `iWrData` = 0xDEADBEEF, `iByteEn` = 1111, then load 0x10:
  - Each access gives `oStall` high 3 cycles, then `oValid` 1 cycle.
  - The load returns `oRdData` = 0xDEADBEEF with `oErr` = 0.
- Byte-lane merge: word 0x20 = 0x11223344, store 0xAABBCCDD with `iByteEn` = 0101, then load 0x20 -> `oRdData` = 0x11BB33DD.
- `WAIT_CYCLES` = 0, back-to-back loads with `iReq` held continuously:
  - `oStall` = 1 in the acceptance cycle, then `oValid` in the next cycle, then one IDLE cycle.
  - No duplicate response for the held request.
- Out of range: load `iAddr` = 0x0001_0000 with `DEPTH_LOG2` = 10 -> `oErr` = 1, `oRdData` = 0. A following store to the same address leaves word 0 unchanged.
- Misaligned load 0x12:
  - With `DMEM_ALIGN_CHECK_EN`: `oErr` = 1, `oRdData` = 0.
  - Without it: returns the word at 0x10 with `oErr` = 0.
- Reset during WAIT of a store of 0xCAFEF00D to 0x40 (word previously 0):
  - `oStall` drops with `iReq`, and no `oValid` follows.
  - The next load of 0x40 returns 0.

Source files
------------

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder for the pipelined MIPS core load/store port.
//
// Accepts one request at a time and holds the pipeline with oStall for
// WAIT_CYCLES wait states. It then completes the access in a single RESP
// cycle, marked by an oValid pulse together with registered read data and
// an error flag.
//
// Parameters:
//   DEPTH_LOG2   log2 of the word count (storage is 2^DEPTH_LOG2 x 32)
//   WAIT_CYCLES  wait states between acceptance and response, 0..15
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   resetn   asynchronous active-low reset
//   iReq     request valid, held by the core until the oValid cycle
//   iWr      1 = store, 0 = load
//   iAddr    byte address
//   iWrData  store data
//   iByteEn  store byte lanes (bit n covers bits [8n+7:8n]), ignored on loads
//   oStall   combinational pipeline freeze: (IDLE & iReq) | WAIT
//   oValid   one-cycle completion pulse (RESP state)
//   oRdData  load data, registered, held until the next load response
//   oErr     access faulted, meaningful only while oValid = 1
//
// Build option:
//   DMEM_ALIGN_CHECK_EN  when defined, any access with iAddr[1:0] != 00
//                        faults. Cycle timing is the same in both builds.

module dmem_resp #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iReq,
    input  logic        iWr,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWrData,
    input  logic [3:0]  iByteEn,
    output logic        oStall,
    output logic        oValid,
    output logic [31:0] oRdData,
    output logic        oErr
);

    localparam int unsigned WORDS = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;
    localparam logic        ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    // Latched request
    logic               wr_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;

    // Storage, intentionally not reset
    logic [31:0]        mem [WORDS];

    // View of the access being completed on this edge
    logic [31:0]        acc_addr;
    logic               acc_wr;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic               go_resp;
    logic               fault;

    // Stall is a pure function of state and the live request
    assign oStall = ((state == ST_IDLE) && iReq) || (state == ST_WAIT);

    // With zero wait states the response edge is also the acceptance edge,
    // so the live inputs are used instead of the (not yet) latched ones.
    always_comb begin
        acc_addr = (state == ST_IDLE) ? iAddr : addr_q;
        acc_wr   = (state == ST_IDLE) ? iWr   : wr_q;
        acc_idx  = acc_addr[DEPTH_LOG2+1:2];
        wr_idx   = addr_q[DEPTH_LOG2+1:2];

        go_resp = 1'b0;
        case (state)
            ST_IDLE: go_resp = iReq && ZERO_WAIT;
            ST_WAIT: go_resp = (cnt == '0);
            default: go_resp = 1'b0;
        endcase

        fault = |acc_addr[31:DEPTH_LOG2+2];
`ifdef DMEM_ALIGN_CHECK_EN
        fault = fault | (acc_addr[1:0] != 2'b00);
`endif
    end

`ifndef DMEM_ALIGN_CHECK_EN
    // Low address bits select nothing in this build
    logic unused_low;
    assign unused_low = ^acc_addr[1:0];
`endif

    // Control FSM, request latch and registered response outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            oValid  <= 1'b0;
            oErr    <= 1'b0;
            oRdData <= '0;
        end else begin
            oValid <= go_resp;
            oErr   <= go_resp & fault;

            // Loads capture on the edge entering RESP; stores leave data alone
            if (go_resp) begin
                if (fault) begin
                    oRdData <= '0;
                end else if (!acc_wr) begin
                    oRdData <= mem[acc_idx];
                end
            end

            case (state)
                ST_IDLE: begin
                    if (iReq) begin
                        wr_q    <= iWr;
                        addr_q  <= iAddr;
                        wdata_q <= iWrData;
                        be_q    <= iByteEn;
                        if (ZERO_WAIT) begin
                            state <= ST_RESP;
                        end else begin
                            cnt   <= CNT_LOAD;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                // The request still on iReq here is the one being answered
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Store commit at the RESP edge; oErr carries the latched fault in RESP.
    // A reset before RESP leaves the word untouched.
    always_ff @(posedge clk) begin
        if ((state == ST_RESP) && wr_q && !oErr) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: self-checking bench for dmem_resp.
// Two instances: dut2 (WAIT_CYCLES = 2) carries the table, reset-abort and
// random phases; dut0 (WAIT_CYCLES = 0) covers zero-wait back-to-back loads.

module tb_dmem_resp;

    localparam int unsigned DEPTH = 10;
    localparam int unsigned WORDS = 1 << DEPTH;
    localparam int unsigned BYTES = 4 * WORDS;
    localparam int unsigned WC2   = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        req0, req2, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        stall0, valid0, err0;
    logic        stall2, valid2, err2;
    logic [31:0] rd0, rd2;

    always #5 clk = ~clk;

    dmem_resp #(.DEPTH_LOG2(DEPTH), .WAIT_CYCLES(WC2)) dut2 (
        .clk(clk), .resetn(resetn), .iReq(req2), .iWr(wr), .iAddr(addr),
        .iWrData(wdata), .iByteEn(be), .oStall(stall2), .oValid(valid2),
        .oRdData(rd2), .oErr(err2)
    );

    dmem_resp #(.DEPTH_LOG2(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .resetn(resetn), .iReq(req0), .iWr(wr), .iAddr(addr),
        .iWrData(wdata), .iByteEn(be), .oStall(stall0), .oValid(valid0),
        .oRdData(rd0), .oErr(err0)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_mask(input string name, input logic [31:0] got,
                              input logic [31:0] exp, input logic [31:0] mask);
        n_vec++;
        if (((got ^ exp) & mask) !== 32'h0) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (mask %h)", name, got, exp, mask);
        end
    endtask

    // Reference model for dut2: word-addressed memory with per-byte known flags
    logic [31:0] mdata  [WORDS];
    logic [3:0]  mknown [WORDS];
    logic [31:0] last_rd, last_mask;

    function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] b, output logic [31:0] er,
                                  output logic [31:0] em, output logic ee);
        int unsigned wi;
        bit f;
        wi = (a / 4) % WORDS;
        f  = (a >= BYTES) || (ALIGN && (a % 4 != 0));
        if (f) begin
            er = 32'h0; em = '1; ee = 1'b1;
            last_rd = 32'h0; last_mask = '1;
        end else if (w) begin
            for (int n = 0; n < 4; n++) begin
                if (b[n]) begin
                    mdata[wi][8*n +: 8] = d[8*n +: 8];
                    mknown[wi][n] = 1'b1;
                end
            end
            er = last_rd; em = last_mask; ee = 1'b0;
        end else begin
            er = mdata[wi];
            em = 32'h0;
            for (int n = 0; n < 4; n++) if (mknown[wi][n]) em[8*n +: 8] = 8'hFF;
            ee = 1'b0;
            last_rd = er; last_mask = em;
        end
    endfunction

    // One request held until oValid; optionally scrambles inputs after acceptance
    task automatic access(input int which, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b, input bit scramble,
                          output logic [31:0] r, output logic e, output int nstall,
                          output int lat, output logic stall_resp);
        bit done;
        logic v, s;
        done = 1'b0;
        @(negedge clk);
        wr = w; addr = a; wdata = d; be = b;
        if (which == 0) req0 = 1'b1; else req2 = 1'b1;
        nstall = 0; lat = -1; stall_resp = 1'b0; r = 'x; e = 1'bx;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            v = (which == 0) ? valid0 : valid2;
            s = (which == 0) ? stall0 : stall2;
            if (v) begin
                done = 1'b1; lat = c; stall_resp = s;
                r = (which == 0) ? rd0 : rd2;
                e = (which == 0) ? err0 : err2;
            end else if (s) begin
                nstall++;
            end
            @(negedge clk);
            if (scramble && !done) begin
                wr = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
            end
        end
        if (which == 0) req0 = 1'b0; else req2 = 1'b0;
    endtask

    task automatic do2(input string name, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input bit scramble,
                       input logic [31:0] exp_rd, input logic [31:0] exp_mask,
                       input logic exp_err);
        logic [31:0] r;
        logic e, sr;
        int ns, lat;
        access(2, w, a, d, b, scramble, r, e, ns, lat, sr);
        check({name, " lat"}, 32'(lat), 32'(WC2 + 1));
        check({name, " stall"}, 32'(ns), 32'(WC2 + 1));
        check({name, " stall_resp"}, 32'(sr), 32'h0);
        check({name, " err"}, 32'(e), 32'(exp_err));
        check_mask({name, " rd"}, r, exp_rd, exp_mask);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [17];

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] er, em, r, a;
        logic ee, e, sr, w;
        int ns, lat, nv, k;

        for (int i = 0; i < int'(WORDS); i++) begin
            mdata[i] = 32'h0; mknown[i] = 4'h0;
        end
        last_rd = 32'h0; last_mask = '1;

        tbl[0]  = '{1'b1, 32'h00, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0};
        tbl[1]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
        tbl[3]  = '{1'b1, 32'h20, 32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0};
        tbl[4]  = '{1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 1'b0};
        tbl[5]  = '{1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0};
        tbl[6]  = '{1'b0, 32'h0001_0000, 32'h0, 4'h0, 32'h0, 1'b1};
        tbl[7]  = '{1'b1, 32'h0001_0000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1};
        tbl[8]  = '{1'b0, 32'h00, 32'h0, 4'h0, 32'h5A5A5A5A, 1'b0};
        tbl[9]  = '{1'b0, 32'h12, 32'h0, 4'h0, ALIGN ? 32'h0 : 32'hDEADBEEF, ALIGN};
        tbl[10] = '{1'b1, 32'h30, 32'h01020304, 4'hF, ALIGN ? 32'h0 : 32'hDEADBEEF, 1'b0};
        tbl[11] = '{1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, ALIGN ? 32'h0 : 32'hDEADBEEF, 1'b0};
        tbl[12] = '{1'b0, 32'h30, 32'h0, 4'h0, 32'h01020304, 1'b0};
        tbl[13] = '{1'b1, 32'h50, 32'h00000000, 4'hF, 32'h01020304, 1'b0};
        tbl[14] = '{1'b1, 32'h51, 32'h77777777, 4'hF, ALIGN ? 32'h0 : 32'h01020304, ALIGN};
        tbl[15] = '{1'b0, 32'h50, 32'h0, 4'h0, ALIGN ? 32'h0 : 32'h77777777, 1'b0};
        tbl[16] = '{1'b1, 32'h40, 32'h00000000, 4'hF, ALIGN ? 32'h0 : 32'h77777777, 1'b0};

        // Reset state
        resetn = 1'b0; req0 = 1'b0; req2 = 1'b0; wr = 1'b0;
        addr = 32'h0; wdata = 32'h0; be = 4'h0;
        repeat (2) @(negedge clk);
        #1;
        check("reset valid", 32'(valid2), 32'h0);
        check("reset err", 32'(err2), 32'h0);
        check("reset rd", rd2, 32'h0);
        check("reset stall idle", 32'(stall2), 32'h0);
        check("reset valid0", 32'(valid0), 32'h0);
        req2 = 1'b1;
        #1;
        check("reset stall follows req", 32'(stall2), 32'h1);
        req2 = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // Directed table on the 2-wait-state instance
        for (int i = 0; i < 17; i++) begin
            model(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, er, em, ee);
            do2($sformatf("row%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be,
                1'b0, tbl[i].exp_rd, 32'hFFFFFFFF, tbl[i].exp_err);
        end

        // Reset during WAIT of a store: abandoned, no commit, no response
        @(negedge clk);
        wr = 1'b1; addr = 32'h40; wdata = 32'hCAFEF00D; be = 4'hF; req2 = 1'b1;
        @(negedge clk);
        #1;
        check("abort stall in wait", 32'(stall2), 32'h1);
        resetn = 1'b0; req2 = 1'b0;
        #1;
        check("abort stall drops", 32'(stall2), 32'h0);
        check("abort rd reset", rd2, 32'h0);
        nv = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 2) resetn = 1'b1;
            #1;
            if (valid2) nv++;
        end
        check("abort no valid", 32'(nv), 32'h0);
        last_rd = 32'h0; last_mask = '1;
        model(1'b0, 32'h40, 32'h0, 4'h0, er, em, ee);
        do2("abort reload", 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b0);

        // Zero wait states
        access(0, 1'b1, 32'h10, 32'h0BADF00D, 4'hF, 1'b0, r, e, ns, lat, sr);
        check("w0 store lat", 32'(lat), 32'h1);
        check("w0 store stall", 32'(ns), 32'h1);
        access(0, 1'b1, 32'h14, 32'h600DCAFE, 4'hF, 1'b0, r, e, ns, lat, sr);
        access(0, 1'b0, 32'h0001_0000, 32'h0, 4'h0, 1'b0, r, e, ns, lat, sr);
        check("w0 range err", 32'(e), 32'h1);
        check("w0 range rd", r, 32'h0);

        // Held iReq: accept, RESP, IDLE(re-accept), RESP
        @(negedge clk);
        wr = 1'b0; addr = 32'h10; req0 = 1'b1;
        #1;
        check("w0 c0 stall", 32'(stall0), 32'h1);
        check("w0 c0 valid", 32'(valid0), 32'h0);
        @(negedge clk);
        addr = 32'h14;
        #1;
        check("w0 c1 valid", 32'(valid0), 32'h1);
        check("w0 c1 stall", 32'(stall0), 32'h0);
        check("w0 c1 rd", rd0, 32'h0BADF00D);
        check("w0 c1 err", 32'(err0), 32'h0);
        @(negedge clk);
        #1;
        check("w0 c2 valid", 32'(valid0), 32'h0);
        check("w0 c2 stall", 32'(stall0), 32'h1);
        @(negedge clk);
        #1;
        check("w0 c3 valid", 32'(valid0), 32'h1);
        check("w0 c3 rd", rd0, 32'h600DCAFE);
        @(negedge clk);
        req0 = 1'b0;
        #1;
        check("w0 c4 valid", 32'(valid0), 32'h0);
        check("w0 c4 stall", 32'(stall0), 32'h0);
        nv = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (valid0) nv++;
        end
        check("w0 no duplicate", 32'(nv), 32'h0);

        // Randomized accesses against the reference model
        for (int i = 0; i < 200; i++) begin
            w = 1'($urandom_range(0, 1));
            k = int'($urandom_range(0, 9));
            if (k <= 5) begin
                a = 32'($urandom_range(0, 31)) * 4;
            end else if (k == 6) begin
                a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
            end else if (k <= 8) begin
                a = $urandom;
                a[12 + int'($urandom_range(0, 19))] = 1'b1;
            end else begin
                a = 32'($urandom_range(0, WORDS - 1)) * 4;
            end
            wdata = $urandom;
            be    = 4'($urandom);
            model(w, a, wdata, be, er, em, ee);
            do2($sformatf("rnd%0d", i), w, a, wdata, be, 1'b1, er, em, ee);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
